// File: rtl/serial_alu_seq_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
package serial_alu_seq_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_seq_alu1.sv
// One-bit ALU slice: AND / OR / full-add with optional B inversion.
module serial_alu_seq_alu1
    import serial_alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    output logic       carry_out,
    input  logic       binvert,
    input  logic [1:0] operation,
    output logic       result
);

    logic bb;

    always_comb begin
        bb        = b ^ binvert;
        carry_out = (a & bb) | (carry_in & (a ^ bb));
        case (operation)
            OP_AND:  result = a & bb;
            OP_OR:   result = a | bb;
            default: result = a ^ bb ^ carry_in;  // reserved 2'b11 behaves as ADD
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial W-bit ALU sequencer: streams operands LSB-first through one ALU1 slice.
//   state   | meaning
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | one operand bit per cycle through the slice
//   DONE    | done pulse; result and flags valid
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   operation,
    input  logic         binvert,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST   = CW'(W - 1);
    localparam logic [CW-1:0] PENULT = CW'(W - 2);

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  a_sr, b_sr, res_sr, res_next;
    logic [1:0]    operation_q;
    logic          binvert_q, carry_q, cin_msb;
    logic          slice_cout, slice_res;

    serial_alu_seq_alu1 u_slice (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_q),
        .carry_out (slice_cout),
        .binvert   (binvert_q),
        .operation (operation_q),
        .result    (slice_res)
    );

    always_comb begin
        res_next = {slice_res, res_sr[W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            operation_q <= OP_AND;
            binvert_q   <= 1'b0;
            carry_q     <= 1'b0;
            cin_msb     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr        <= a;
                        b_sr        <= b;
                        operation_q <= operation;
                        binvert_q   <= binvert;
                        carry_q     <= binvert;
                        count       <= '0;
                        busy        <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry_q <= slice_cout;
                    count   <= count + CW'(1);
                    if (count == PENULT)
                        cin_msb <= slice_cout;
                    if (count == LAST) begin
                        // operation_q[1] marks the arithmetic ops (ADD and reserved 11)
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        result    <= res_next;
                        carry_out <= operation_q[1] & slice_cout;
                        overflow  <= operation_q[1] & (cin_msb ^ slice_cout);
                        zero      <= (res_next == '0);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed scoreboard bench for serial_alu_seq at W=8.
module tb_serial_alu_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   operation;
    logic         binvert;
    logic [W-1:0] a, b;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    serial_alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operation (operation),
        .binvert   (binvert),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic binv,
                                   input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb = binv ? ~bv : bv;
        e  = '0;
        case (op)
            2'b00: e.r = av & bb;
            2'b01: e.r = av | bb;
            default: begin
                s   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, binv};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (av[W-1] == bb[W-1]) && (e.r[W-1] != av[W-1]);
            end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Issues one op at a negedge, then watches a fixed window of cycles.
    task automatic run_op(input string tag, input logic [1:0] op, input logic binv,
                          input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        int   done_cnt, busy_cnt, done_at;
        exp_t e, got;
        @(negedge clk);
        operation = op; binvert = binv; a = av; b = bv; start = 1'b1;
        sb_q.push_back(model(op, binv, av, bv));
        done_cnt = 0; busy_cnt = 0; done_at = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (hold && n < W + 2) begin
                a = ~av; b = av ^ bv; operation = 2'b01; binvert = ~binv;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
                got = '{r: result, c: carry_out, v: overflow, z: zero};
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({tag, ".result"},   32'(got.r), 32'(e.r));
                    check({tag, ".carry"},    32'(got.c), 32'(e.c));
                    check({tag, ".overflow"}, 32'(got.v), 32'(e.v));
                    check({tag, ".zero"},     32'(got.z), 32'(e.z));
                end
            end
        end
        start = 1'b0;
        check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, ".latency"},     32'(done_at),  32'(W + 1));
        check({tag, ".busy_width"},  32'(busy_cnt), 32'(W + 1));
        check({tag, ".sb_empty"},    32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int   done_seen;
        logic [W-1:0] held;
        rst_n = 1'b0; start = 1'b0; operation = 2'b00; binvert = 1'b0; a = '0; b = '0;
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_35_4a", 2'b10, 1'b0, 8'h35, 8'h4A, 1'b0);
        run_op("add_ff_01", 2'b10, 1'b0, 8'hFF, 8'h01, 1'b0);
        run_op("add_7f_01", 2'b10, 1'b0, 8'h7F, 8'h01, 1'b0);
        run_op("sub_10_20", 2'b10, 1'b1, 8'h10, 8'h20, 1'b0);
        run_op("sub_80_01", 2'b10, 1'b1, 8'h80, 8'h01, 1'b0);
        run_op("and_f0_3c", 2'b00, 1'b0, 8'hF0, 8'h3C, 1'b0);
        run_op("or_f0_0c",  2'b01, 1'b0, 8'hF0, 8'h0C, 1'b0);
        run_op("rsv_c3_5a", 2'b11, 1'b0, 8'hC3, 8'h5A, 1'b0);
        run_op("sub_55_55", 2'b10, 1'b1, 8'h55, 8'h55, 1'b0);

        held = result;
        repeat (3) @(negedge clk);
        check("idle.result_stable", 32'(result), 32'(held));

        run_op("hold_start", 2'b10, 1'b0, 8'h12, 8'h34, 1'b0 == 1'b1 ? 1'b0 : 1'b1);

        // abort mid-RUN
        @(negedge clk);
        operation = 2'b10; binvert = 1'b0; a = 8'h21; b = 8'h43; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", 32'(result), 32'd0);
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (n == 2) rst_n = 1'b1;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);

        run_op("after_abort", 2'b10, 1'b0, 8'h9C, 8'h64, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
